// File: rtl/kd_tree_root_ctrl_if.sv
// Root-controller bus bundle: host start/done, center-load handshake and tree command/data link.
interface kd_tree_root_ctrl_if #(
    parameter int unsigned DIMS    = 3,
    parameter int unsigned COORD_W = 16,
    parameter int unsigned CMD_W   = 3
);
    localparam int unsigned DATA_W = DIMS * COORD_W;
    localparam int unsigned AXIS_W = (DIMS > 1) ? $clog2(DIMS) : 1;

    // host control and status
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              timeout_err;
    logic [AXIS_W-1:0] cur_axis;

    // center-load handshake
    logic              center_valid;
    logic [DATA_W-1:0] center_in;
    logic              center_ready;

    // link to the top tree node
    logic [CMD_W-1:0]  cmd_to_tree;
    logic [DATA_W-1:0] data_to_tree;
    logic [CMD_W-1:0]  cmd_from_tree;

    // controller side
    modport slave (
        input  start, abort, center_valid, center_in, cmd_from_tree,
        output center_ready, cmd_to_tree, data_to_tree, busy, done, timeout_err, cur_axis
    );

    // host / tree side
    modport master (
        output start, abort, center_valid, center_in, cmd_from_tree,
        input  center_ready, cmd_to_tree, data_to_tree, busy, done, timeout_err, cur_axis
    );
endinterface

// File: rtl/kd_tree_root_ctrl.sv
// Root-side sequencer for the kd-tree: loads NUM_CENTERS centers, then configures and
// sorts each axis in turn, guarding every wait on the tree with a timeout watchdog.
module kd_tree_root_ctrl #(
    parameter int unsigned DIMS        = 3,
    parameter int unsigned COORD_W     = 16,
    parameter int unsigned NUM_CENTERS = 8,
    parameter int unsigned CMD_W       = 3,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    kd_tree_root_ctrl_if.slave bus
);
    localparam int unsigned DATA_W = DIMS * COORD_W;
    localparam int unsigned AXIS_W = (DIMS > 1) ? $clog2(DIMS) : 1;
    localparam int unsigned CNT_W  = $clog2(NUM_CENTERS + 1);
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CMD_W-1:0] CMD_NOP           = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_CENTER_FILL   = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_CENTER_DONE   = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_CFG_AXIS      = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_CFG_AXIS_DONE = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_START_SORT    = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_SORT_DONE     = CMD_W'(6);

    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(NUM_CENTERS);
    localparam logic [AXIS_W-1:0] LAST_AXIS  = AXIS_W'(DIMS - 1);
    localparam logic [TO_W-1:0]   LAST_TICK  = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL_ACCEPT,
        S_FILL_WAIT,
        S_FILL_GAP,
        S_AXIS_WAIT,
        S_SORT_WAIT,
        S_SORT_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] center_cnt;
    logic [TO_W-1:0]  wait_cnt;

    // Sequencer: state, counters and every output are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_IDLE;
            center_cnt       <= '0;
            wait_cnt         <= '0;
            bus.cmd_to_tree  <= CMD_NOP;
            bus.data_to_tree <= '0;
            bus.center_ready <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.cur_axis     <= '0;
        end else begin
            bus.done <= 1'b0;
            if (bus.abort) begin
                // abort discards all progress and clears the error
                state            <= S_IDLE;
                center_cnt       <= '0;
                wait_cnt         <= '0;
                bus.cmd_to_tree  <= CMD_NOP;
                bus.data_to_tree <= '0;
                bus.center_ready <= 1'b0;
                bus.busy         <= 1'b0;
                bus.timeout_err  <= 1'b0;
                bus.cur_axis     <= '0;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (bus.start) begin
                            state            <= S_FILL_ACCEPT;
                            center_cnt       <= '0;
                            wait_cnt         <= '0;
                            bus.cmd_to_tree  <= CMD_NOP;
                            bus.center_ready <= 1'b1;
                            bus.busy         <= 1'b1;
                            bus.timeout_err  <= 1'b0;
                            bus.cur_axis     <= '0;
                        end
                    end

                    // host may stall here indefinitely, so no watchdog
                    S_FILL_ACCEPT: begin
                        if (bus.center_valid && bus.center_ready) begin
                            state            <= S_FILL_WAIT;
                            wait_cnt         <= '0;
                            bus.data_to_tree <= bus.center_in;
                            bus.cmd_to_tree  <= CMD_CENTER_FILL;
                            bus.center_ready <= 1'b0;
                        end
                    end

                    S_FILL_WAIT: begin
                        if (bus.cmd_from_tree == CMD_CENTER_DONE) begin
                            state           <= S_FILL_GAP;
                            center_cnt      <= center_cnt + CNT_W'(1);
                            bus.cmd_to_tree <= CMD_NOP;
                        end else if (wait_cnt == LAST_TICK) begin
                            state           <= S_ERR;
                            bus.cmd_to_tree <= CMD_NOP;
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end

                    // one NOP cycle so the tree sees a fresh command edge
                    S_FILL_GAP: begin
                        if (center_cnt == LAST_COUNT) begin
                            state            <= S_AXIS_WAIT;
                            wait_cnt         <= '0;
                            bus.cmd_to_tree  <= CMD_CFG_AXIS;
                            bus.data_to_tree <= DATA_W'(bus.cur_axis);
                        end else begin
                            state            <= S_FILL_ACCEPT;
                            bus.center_ready <= 1'b1;
                        end
                    end

                    S_AXIS_WAIT: begin
                        if (bus.cmd_from_tree == CMD_CFG_AXIS_DONE) begin
                            state            <= S_SORT_WAIT;
                            wait_cnt         <= '0;
                            bus.cmd_to_tree  <= CMD_START_SORT;
                            bus.data_to_tree <= '0;
                        end else if (wait_cnt == LAST_TICK) begin
                            state           <= S_ERR;
                            bus.cmd_to_tree <= CMD_NOP;
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end

                    S_SORT_WAIT: begin
                        if (bus.cmd_from_tree == CMD_SORT_DONE) begin
                            state           <= S_SORT_GAP;
                            bus.cmd_to_tree <= CMD_NOP;
                        end else if (wait_cnt == LAST_TICK) begin
                            state           <= S_ERR;
                            bus.cmd_to_tree <= CMD_NOP;
                            bus.timeout_err <= 1'b1;
                            bus.busy        <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end

                    // last axis finishes the run; cur_axis never wraps
                    S_SORT_GAP: begin
                        if (bus.cur_axis == LAST_AXIS) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            state            <= S_AXIS_WAIT;
                            wait_cnt         <= '0;
                            bus.cur_axis     <= bus.cur_axis + AXIS_W'(1);
                            bus.cmd_to_tree  <= CMD_CFG_AXIS;
                            bus.data_to_tree <= DATA_W'(bus.cur_axis + AXIS_W'(1));
                        end
                    end

                    // start in this cycle is deliberately not sampled
                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state            <= S_IDLE;
                        bus.cmd_to_tree  <= CMD_NOP;
                        bus.center_ready <= 1'b0;
                        bus.busy         <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// Directed bench for kd_tree_root_ctrl with a latency-4 tree responder and a command monitor.
module tb_kd_tree_root_ctrl;
    localparam int unsigned DIMS        = 3;
    localparam int unsigned COORD_W     = 16;
    localparam int unsigned NUM_CENTERS = 8;
    localparam int unsigned CMD_W       = 3;
    localparam int unsigned TIMEOUT     = 16;
    localparam int          LAT         = 4;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_CF   = 3'd1;
    localparam logic [2:0] C_CFD  = 3'd2;
    localparam logic [2:0] C_CFG  = 3'd3;
    localparam logic [2:0] C_CFGD = 3'd4;
    localparam logic [2:0] C_SS   = 3'd5;
    localparam logic [2:0] C_SD   = 3'd6;
    localparam logic [2:0] C_RSV  = 3'd7;
    localparam logic [47:0] BASE  = 48'h0001_0002_0003;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kd_tree_root_ctrl_if #(.DIMS(DIMS), .COORD_W(COORD_W), .CMD_W(CMD_W)) bus ();

    kd_tree_root_ctrl #(
        .DIMS(DIMS), .COORD_W(COORD_W), .NUM_CENTERS(NUM_CENTERS),
        .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // tree model controls
    logic       auto_en   = 1'b1;
    logic       ovr_en    = 1'b0;
    logic [2:0] ovr_val   = 3'd0;
    logic       mute_en   = 1'b0;
    logic [2:0] mute_cmd  = 3'd0;
    logic [1:0] mute_axis = 2'd0;
    logic [2:0] m_last    = 3'd0;
    int         m_age     = 0;

    function automatic logic [2:0] resp_of(input logic [2:0] c);
        case (c)
            C_CF:    return C_CFD;
            C_CFG:   return C_CFGD;
            C_SS:    return C_SD;
            default: return C_NOP;
        endcase
    endfunction

    // Tree responder: answers a held command after LAT cycles
    always @(negedge clk) begin
        if (bus.cmd_to_tree !== m_last) begin
            m_last = bus.cmd_to_tree;
            m_age  = 0;
        end else begin
            m_age = m_age + 1;
        end
        if (ovr_en)
            bus.cmd_from_tree <= ovr_val;
        else if (auto_en && m_age >= LAT - 1 &&
                 !(mute_en && m_last == mute_cmd && bus.cur_axis == mute_axis))
            bus.cmd_from_tree <= resp_of(m_last);
        else
            bus.cmd_from_tree <= C_NOP;
    end

    typedef struct packed {
        logic [2:0]  cmd;
        logic [47:0] data;
        logic [31:0] cyc;
    } ev_t;

    ev_t         mon_q[$];
    ev_t         mon_ev;
    logic [2:0]  mon_last = 3'd0;
    logic [31:0] cyc_cnt  = 0;
    int          done_cnt = 0;

    // Command monitor: logs every change of cmd_to_tree and counts done pulses
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (bus.done === 1'b1) done_cnt = done_cnt + 1;
        if (bus.cmd_to_tree !== mon_last) begin
            mon_ev.cmd  = bus.cmd_to_tree;
            mon_ev.data = bus.data_to_tree;
            mon_ev.cyc  = cyc_cnt;
            mon_q.push_back(mon_ev);
            mon_last = bus.cmd_to_tree;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic load_center(input logic [47:0] v, output bit ok);
        int n = 0;
        bus.center_valid = 1'b1;
        bus.center_in    = v;
        while (bus.center_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        ok = (bus.center_ready === 1'b1);
        if (ok) tick();
        bus.center_valid = 1'b0;
    endtask

    task automatic load_range(input int first, input int last, output int fails);
        bit ok;
        fails = 0;
        for (int i = first; i <= last; i++) begin
            load_center(BASE + 48'(i), ok);
            if (!ok) fails++;
        end
    endtask

    task automatic wait_cmd(input logic [2:0] c, input bit any_axis, input logic [1:0] ax,
                            output bit ok);
        int n = 0;
        while (!(bus.cmd_to_tree === c && (any_axis || bus.cur_axis === ax)) && n < 400) begin
            tick();
            n++;
        end
        ok = (bus.cmd_to_tree === c && (any_axis || bus.cur_axis === ax));
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        ok = (bus.done === 1'b1);
    endtask

    task automatic test_reset();
        #10;
        checks++;
        if (bus.cmd_to_tree !== C_NOP || bus.data_to_tree !== 48'h0) begin
            errors++;
            $display("FAIL reset_bus: cmd=%0h data=%0h want 0/0", bus.cmd_to_tree, bus.data_to_tree);
        end
        checks++;
        if ({bus.center_ready, bus.busy, bus.done, bus.timeout_err} !== 4'b0000 || bus.cur_axis !== 2'd0) begin
            errors++;
            $display("FAIL reset_flags: rdy/busy/done/err=%b axis=%0d want 0000/0",
                     {bus.center_ready, bus.busy, bus.done, bus.timeout_err}, bus.cur_axis);
        end
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.center_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b rdy=%b want 0/0", bus.busy, bus.center_ready);
        end
    endtask

    task automatic test_full_run();
        int          base_idx;
        int          d0;
        int          fails;
        bit          ok;
        logic [2:0]  exp_cmd[25];
        logic [47:0] exp_data[25];
        bit          exp_chk[25];
        base_idx = mon_q.size();
        d0       = done_cnt;
        do_start();
        checks++;
        if (bus.center_ready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL start_accept: rdy=%b busy=%b want 1/1", bus.center_ready, bus.busy);
        end
        load_range(0, 7, fails);
        checks++;
        if (fails != 0) begin
            errors++;
            $display("FAIL full_loads: %0d center loads stalled want 0", fails);
        end
        wait_done(ok);
        checks++;
        if (!ok || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b busy=%b want 1/0", bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b busy=%b want 0/0", bus.done, bus.busy);
        end
        tick();
        tick();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_count: %0d pulses want 1", done_cnt - d0);
        end
        for (int i = 0; i < 8; i++) begin
            exp_cmd[2*i]    = C_CF;
            exp_data[2*i]   = BASE + 48'(i);
            exp_chk[2*i]    = 1'b1;
            exp_cmd[2*i+1]  = C_NOP;
            exp_data[2*i+1] = 48'h0;
            exp_chk[2*i+1]  = 1'b0;
        end
        for (int a = 0; a < 3; a++) begin
            exp_cmd[16+3*a]  = C_CFG;
            exp_data[16+3*a] = 48'(a);
            exp_chk[16+3*a]  = 1'b1;
            exp_cmd[17+3*a]  = C_SS;
            exp_data[17+3*a] = 48'h0;
            exp_chk[17+3*a]  = 1'b1;
            exp_cmd[18+3*a]  = C_NOP;
            exp_data[18+3*a] = 48'h0;
            exp_chk[18+3*a]  = 1'b0;
        end
        checks++;
        if (mon_q.size() - base_idx != 25) begin
            errors++;
            $display("FAIL cmd_seq_len: %0d command changes want 25", mon_q.size() - base_idx);
        end
        for (int k = 0; k < 25; k++) begin
            if (base_idx + k < mon_q.size()) begin
                checks++;
                if (mon_q[base_idx+k].cmd !== exp_cmd[k] ||
                    (exp_chk[k] && mon_q[base_idx+k].data !== exp_data[k])) begin
                    errors++;
                    $display("FAIL cmd_seq[%0d]: cmd=%0d data=%0h want cmd=%0d data=%0h",
                             k, mon_q[base_idx+k].cmd, mon_q[base_idx+k].data, exp_cmd[k], exp_data[k]);
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            int k = 15 + 3 * j;
            if (base_idx + k + 1 < mon_q.size()) begin
                checks++;
                if (mon_q[base_idx+k+1].cyc - mon_q[base_idx+k].cyc != 1) begin
                    errors++;
                    $display("FAIL gap_len[%0d]: %0d NOP cycles want 1", k,
                             mon_q[base_idx+k+1].cyc - mon_q[base_idx+k].cyc);
                end
            end
        end
    endtask

    task automatic test_host_stall();
        int fails;
        int bad = 0;
        int n   = 0;
        bit ok;
        do_start();
        load_range(0, 3, fails);
        while (bus.center_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (fails != 0 || bus.center_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup: fails=%0d rdy=%b want 0/1", fails, bus.center_ready);
        end
        for (int i = 0; i < 50; i++) begin
            if (bus.center_ready !== 1'b1 || bus.cmd_to_tree !== C_NOP || bus.timeout_err !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || bus.center_ready !== 1'b1 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL host_stall: %0d bad cycles rdy=%b err=%b want 0/1/0", bad,
                     bus.center_ready, bus.timeout_err);
        end
        load_range(4, 7, fails);
        wait_done(ok);
        checks++;
        if (fails != 0 || !ok) begin
            errors++;
            $display("FAIL stall_finish: fails=%0d done=%b want 0/1", fails, ok);
        end
        tick();
    endtask

    task automatic test_timeout();
        int fails;
        int n = 0;
        bit ok;
        mute_en   = 1'b1;
        mute_cmd  = C_SS;
        mute_axis = 2'd1;
        do_start();
        load_range(0, 7, fails);
        wait_cmd(C_SS, 1'b0, 2'd1, ok);
        checks++;
        if (fails != 0 || !ok) begin
            errors++;
            $display("FAIL to_reach_sort1: fails=%0d reached=%b want 0/1", fails, ok);
        end
        while (bus.cmd_to_tree === C_SS && n < 100) begin
            n++;
            tick();
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL to_len: %0d START_SORT cycles want %0d", n, TIMEOUT);
        end
        checks++;
        if (bus.cmd_to_tree !== C_NOP || bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL to_err: cmd=%0d err=%b busy=%b want 0/1/0",
                     bus.cmd_to_tree, bus.timeout_err, bus.busy);
        end
        mute_en = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bus.timeout_err !== 1'b1 || bus.center_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: err=%b rdy=%b busy=%b want 1/0/0",
                     bus.timeout_err, bus.center_ready, bus.busy);
        end
        do_start();
        checks++;
        if (bus.timeout_err !== 1'b0 || bus.center_ready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL err_restart: err=%b rdy=%b busy=%b want 0/1/1",
                     bus.timeout_err, bus.center_ready, bus.busy);
        end
        load_center(BASE, ok);
        checks++;
        if (!ok || bus.cmd_to_tree !== C_CF || bus.data_to_tree !== BASE) begin
            errors++;
            $display("FAIL err_refill: cmd=%0d data=%0h want %0d/%0h", bus.cmd_to_tree,
                     bus.data_to_tree, C_CF, BASE);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_last_cycle_response();
        int fails;
        bit ok;
        do_start();
        load_range(0, 7, fails);
        wait_cmd(C_CFG, 1'b0, 2'd0, ok);
        ovr_en  = 1'b1;
        ovr_val = C_NOP;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++;
        if (fails != 0 || !ok || bus.cmd_to_tree !== C_CFG || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL last_cyc_hold: fails=%0d cmd=%0d err=%b want 0/%0d/0",
                     fails, bus.cmd_to_tree, bus.timeout_err, C_CFG);
        end
        ovr_val = C_CFGD;
        tick();
        ovr_en = 1'b0;
        checks++;
        if (bus.cmd_to_tree !== C_SS || bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL last_cyc_resp: cmd=%0d err=%b busy=%b want %0d/0/1",
                     bus.cmd_to_tree, bus.timeout_err, bus.busy, C_SS);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL last_cyc_finish: done=%b want 1", bus.done);
        end
        tick();
    endtask

    task automatic test_stray_codes();
        int fails;
        bit ok;
        bit ok0;
        do_start();
        load_center(BASE, ok0);
        ovr_en  = 1'b1;
        ovr_val = C_SD;
        tick();
        tick();
        ovr_val = C_RSV;
        tick();
        tick();
        checks++;
        if (!ok0 || bus.cmd_to_tree !== C_CF || bus.data_to_tree !== BASE || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL stray_hold: cmd=%0d data=%0h err=%b want %0d/%0h/0",
                     bus.cmd_to_tree, bus.data_to_tree, bus.timeout_err, C_CF, BASE);
        end
        ovr_en = 1'b0;
        load_range(1, 7, fails);
        wait_cmd(C_CFG, 1'b0, 2'd0, ok);
        checks++;
        if (fails != 0 || !ok) begin
            errors++;
            $display("FAIL stray_count: stalled loads=%0d cfg_seen=%b want 0/1", fails, ok);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_abort();
        int fails;
        bit ok;
        do_start();
        load_range(0, 7, fails);
        wait_cmd(C_CFG, 1'b0, 2'd1, ok);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (!ok || fails != 0 || bus.cmd_to_tree !== C_NOP || bus.data_to_tree !== 48'h0 ||
            {bus.center_ready, bus.busy, bus.done, bus.timeout_err} !== 4'b0000 || bus.cur_axis !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: cmd=%0d data=%0h flags=%b axis=%0d want 0/0/0000/0",
                     bus.cmd_to_tree, bus.data_to_tree,
                     {bus.center_ready, bus.busy, bus.done, bus.timeout_err}, bus.cur_axis);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        do_start();
        load_center(BASE, ok);
        checks++;
        if (!ok || bus.cmd_to_tree !== C_CF || bus.data_to_tree !== BASE) begin
            errors++;
            $display("FAIL reset_refill: cmd=%0d data=%0h want %0d/%0h", bus.cmd_to_tree,
                     bus.data_to_tree, C_CF, BASE);
        end
        load_range(1, 7, fails);
        wait_cmd(C_SS, 1'b0, 2'd0, ok);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (fails != 0 || !ok || bus.cmd_to_tree !== C_NOP || bus.busy !== 1'b0 ||
            bus.center_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: cmd=%0d busy=%b rdy=%b want 0/0/0",
                     bus.cmd_to_tree, bus.busy, bus.center_ready);
        end
        do_start();
        load_range(0, 7, fails);
        wait_done(ok);
        checks++;
        if (fails != 0 || !ok) begin
            errors++;
            $display("FAIL abort_rerun: stalled loads=%0d done=%b want 0/1", fails, ok);
        end
        tick();
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.center_valid = 1'b0;
        bus.center_in    = '0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        test_reset();
        test_full_run();
        test_host_stall();
        test_timeout();
        test_last_cycle_response();
        test_stray_codes();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
